// File: rtl/nvme_ctrl_pkg.sv
// Shared types for the NVMe AFU command slot manager.
package nvme_ctrl_pkg;

  localparam int DATA_W = 771;
  localparam int DEPTH  = 8;
  localparam int AW     = 3;

  typedef logic [AW-1:0] slot_id_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    QUEUED = 2'd1,
    ISSUED = 2'd2
  } slot_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    slot_id_t          slot;
  } out_ent_t;

  function automatic slot_id_t lowest_set(
    input logic [DEPTH-1:0] v
  );
    slot_id_t s;
    s = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (v[i]) s = slot_id_t'(i);
    end
    return s;
  endfunction

endpackage

// File: rtl/nvme_slot_id_fifo.sv
// Slot-id FIFO holding dispatch order of accepted entries.
module nvme_slot_id_fifo
  import nvme_ctrl_pkg::*;
(
  input  logic     clock,
  input  logic     reset_n,
  input  logic     push,
  input  slot_id_t wdata,
  input  logic     pop,
  output slot_id_t head,
  output logic     empty,
  output logic     full
);

  slot_id_t    mem [DEPTH];
  slot_id_t    wr_ptr;
  slot_id_t    rd_ptr;
  logic [AW:0] cnt;
  logic        do_push;
  logic        do_pop;

  assign head    = mem[rd_ptr];
  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/nvme_slot_queue_ctrl.sv
// Slot allocator, dispatcher and lookup front-end for the command RAM.
module nvme_slot_queue_ctrl
  import nvme_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              ram_wren,
  output logic [AW-1:0]     ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [AW-1:0]     ram_raddr_a,
  input  logic [DATA_W-1:0] ram_q_a,
  output logic [AW-1:0]     ram_raddr_b,
  input  logic [DATA_W-1:0] ram_q_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [AW-1:0]     out_slot,
  input  logic              lkp_req,
  input  logic [AW-1:0]     lkp_slot,
  output logic              lkp_rsp_valid,
  output logic              lkp_rsp_err,
  output logic [DATA_W-1:0] lkp_rsp_data,
  input  logic              rel_valid,
  input  logic [AW-1:0]     rel_slot,
  output logic              rel_err,
  output logic [AW:0]       free_count
);

  slot_state_e st [DEPTH];
  logic [AW:0] fcnt;
  logic        pend;
  slot_id_t    pend_slot;
  out_ent_t    buf0;
  out_ent_t    buf1;
  logic [1:0]  buf_cnt;
  logic        lkp_v_q;
  logic        lkp_e_q;
  logic        rel_err_q;

  logic [DEPTH-1:0] free_vec;
  slot_id_t         alloc;
  logic             accept;
  logic             rel_ok;
  logic             fifo_push;
  logic             fifo_empty;
  logic             fifo_full;
  slot_id_t         fifo_head;
  out_ent_t         pend_ent;
  out_ent_t         q0;
  out_ent_t         q1;
  logic [1:0]       occ_n;
  logic [1:0]       occ;
  logic             out_pop;
  logic             issue;

  always_comb begin
    free_vec = '0;
    for (int i = 0; i < DEPTH; i++)
      free_vec[i] = (st[i] == FREE);
  end

  assign alloc     = lowest_set(free_vec);
  assign in_ready  = (fcnt != '0);
  assign accept    = in_valid && in_ready;
  assign fifo_push = accept && !fifo_full;
  assign rel_ok    = rel_valid &&
                     (st[rel_slot] == ISSUED);

  assign ram_wren  = accept;
  assign ram_waddr = accept ? alloc : '0;
  assign ram_wdata = in_data;

  assign ram_raddr_b  = lkp_slot;
  assign lkp_rsp_data = ram_q_b;

  // Head of line is the oldest buffered entry,
  // else the read returning this cycle.
  assign pend_ent = '{data: ram_q_a,
                      slot: pend_slot};

  always_comb begin
    q0 = pend_ent;
    q1 = pend_ent;
    unique case (1'b1)
      buf_cnt == 2'd2: begin
        q0 = buf0;
        q1 = buf1;
      end
      buf_cnt == 2'd1: q0 = buf0;
      default: ;
    endcase
  end

  assign occ_n     = buf_cnt + {1'b0, pend};
  assign out_valid = (occ_n != 2'd0);
  assign out_data  = out_valid ? q0.data : '0;
  assign out_slot  = out_valid ? q0.slot : '0;
  assign out_pop   = out_valid && out_ready;
  assign occ       = occ_n - {1'b0, out_pop};
  assign issue     = !fifo_empty &&
                     (occ < 2'd2);

  assign ram_raddr_a = issue ? fifo_head : '0;

  nvme_slot_id_fifo u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (fifo_push),
    .wdata   (alloc),
    .pop     (issue),
    .head    (fifo_head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) st[i] <= FREE;
      fcnt      <= (AW+1)'(DEPTH);
      pend      <= 1'b0;
      pend_slot <= '0;
      buf0      <= '0;
      buf1      <= '0;
      buf_cnt   <= 2'd0;
      lkp_v_q   <= 1'b0;
      lkp_e_q   <= 1'b0;
      rel_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (accept && alloc == slot_id_t'(i))
          st[i] <= QUEUED;
        else if (out_pop &&
                 q0.slot == slot_id_t'(i))
          st[i] <= ISSUED;
        else if (rel_ok &&
                 rel_slot == slot_id_t'(i))
          st[i] <= FREE;
      end
      fcnt <= fcnt
            + {{AW{1'b0}}, rel_ok}
            - {{AW{1'b0}}, accept};
      pend <= issue;
      if (issue) pend_slot <= fifo_head;
      buf_cnt   <= occ;
      buf0      <= out_pop ? q1 : q0;
      buf1      <= q1;
      lkp_v_q   <= lkp_req;
      lkp_e_q   <= lkp_req &&
                   (st[lkp_slot] == FREE);
      rel_err_q <= rel_valid && !rel_ok;
    end
  end

  assign lkp_rsp_valid = lkp_v_q;
  assign lkp_rsp_err   = lkp_e_q;
  assign rel_err       = rel_err_q;
  assign free_count    = fcnt;

endmodule

// File: tb/tb_nvme_slot_queue_ctrl.sv
// Directed bench for nvme_slot_queue_ctrl with a slot-level reference model.
module tb_nvme_slot_queue_ctrl;
  import nvme_ctrl_pkg::*;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              ram_wren;
  logic [AW-1:0]     ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [AW-1:0]     ram_raddr_a;
  logic [DATA_W-1:0] ram_q_a;
  logic [AW-1:0]     ram_raddr_b;
  logic [DATA_W-1:0] ram_q_b;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [AW-1:0]     out_slot;
  logic              lkp_req = 1'b0;
  logic [AW-1:0]     lkp_slot = '0;
  logic              lkp_rsp_valid;
  logic              lkp_rsp_err;
  logic [DATA_W-1:0] lkp_rsp_data;
  logic              rel_valid = 1'b0;
  logic [AW-1:0]     rel_slot = '0;
  logic              rel_err;
  logic [AW:0]       free_count;

  int nvec = 0;
  int nerr = 0;

  nvme_slot_queue_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data),
    .ram_wren(ram_wren), .ram_waddr(ram_waddr),
    .ram_wdata(ram_wdata),
    .ram_raddr_a(ram_raddr_a), .ram_q_a(ram_q_a),
    .ram_raddr_b(ram_raddr_b), .ram_q_b(ram_q_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_slot(out_slot),
    .lkp_req(lkp_req), .lkp_slot(lkp_slot),
    .lkp_rsp_valid(lkp_rsp_valid),
    .lkp_rsp_err(lkp_rsp_err),
    .lkp_rsp_data(lkp_rsp_data),
    .rel_valid(rel_valid), .rel_slot(rel_slot),
    .rel_err(rel_err), .free_count(free_count)
  );

  always #5 clock = ~clock;

  // Two-read-port RAM with one cycle read latency
  logic [DATA_W-1:0] ram [DEPTH];
  always @(posedge clock) begin
    if (ram_wren) ram[ram_waddr] <= ram_wdata;
    ram_q_a <= ram[ram_raddr_a];
    ram_q_b <= ram[ram_raddr_b];
  end

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s got=%0h want=%0h",
               nm, got, want);
    end
  endtask

  task automatic chkd(input string nm,
                      input logic [DATA_W-1:0] got,
                      input logic [DATA_W-1:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s got[63:0]=%h want[63:0]=%h",
               nm, got[63:0], want[63:0]);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk(input int k);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int i = 0; i < 24; i++)
      d[i*32 +: 32] = 32'(k) ^ (32'(i) << 20)
                    ^ 32'h5A000000;
    d[DATA_W-1 -: 3] = 3'(k);
    return d;
  endfunction

  // Model: slot states (0 free, 1 queued, 2 issued), contents, and
  // an arrival-ordered list with the edge at which each may be shown.
  typedef struct {
    int slot;
    int rdy;
  } qe_t;

  int                mst [DEPTH];
  logic [DATA_W-1:0] mdat [DEPTH];
  qe_t               mq [$];
  int                ecount = 0;
  logic              e_lv = 1'b0;
  logic              e_le = 1'b0;
  logic              e_re = 1'b0;
  logic [DATA_W-1:0] e_ld = '0;

  function automatic int m_fc();
    int c;
    c = 0;
    for (int i = 0; i < DEPTH; i++)
      if (mst[i] == 0) c++;
    return c;
  endfunction

  function automatic int m_alloc();
    for (int i = 0; i < DEPTH; i++)
      if (mst[i] == 0) return i;
    return 0;
  endfunction

  function automatic bit m_ov();
    return mq.size() > 0 && ecount >= mq[0].rdy;
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mst[i]  = 0;
      mdat[i] = '0;
    end
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        for (int i = 0; i < DEPTH; i++) mst[i] = 0;
        mq.delete();
        e_lv = 1'b0;
        e_le = 1'b0;
        e_re = 1'b0;
      end else begin
        bit pop, acc, rok;
        int al;
        pop  = m_ov() && out_ready;
        acc  = in_valid && m_fc() != 0;
        al   = m_alloc();
        rok  = rel_valid && mst[rel_slot] == 2;
        e_lv = lkp_req;
        e_le = lkp_req && mst[lkp_slot] == 0;
        e_ld = mdat[lkp_slot];
        e_re = rel_valid && !rok;
        if (pop) begin
          mst[mq[0].slot] = 2;
          void'(mq.pop_front());
        end
        if (rok) mst[rel_slot] = 0;
        ecount++;
        if (acc) begin
          qe_t e;
          e.slot = al;
          e.rdy  = ecount + 1;
          mst[al]  = 1;
          mdat[al] = in_data;
          mq.push_back(e);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (reset_n) begin
        int fc, al;
        bit acc, ov;
        fc  = m_fc();
        al  = m_alloc();
        acc = in_valid && fc != 0;
        ov  = m_ov();
        chk("free_count", 64'(free_count), 64'(fc));
        chk("in_ready", 64'(in_ready), 64'(fc != 0));
        chk("ram_wren", 64'(ram_wren), 64'(acc));
        if (acc) begin
          chk("ram_waddr", 64'(ram_waddr), 64'(al));
          chkd("ram_wdata", ram_wdata, in_data);
        end
        chk("out_valid", 64'(out_valid), 64'(ov));
        if (ov) begin
          chk("out_slot", 64'(out_slot),
              64'(mq[0].slot));
          chkd("out_data", out_data,
               mdat[mq[0].slot]);
        end
        if (mq.size() == 0)
          chk("ram_raddr_a_idle", 64'(ram_raddr_a), 0);
        chk("lkp_rsp_valid", 64'(lkp_rsp_valid),
            64'(e_lv));
        if (e_lv)
          chk("lkp_rsp_err", 64'(lkp_rsp_err), 64'(e_le));
        if (e_lv && !e_le)
          chkd("lkp_rsp_data", lkp_rsp_data, e_ld);
        chk("rel_err", 64'(rel_err), 64'(e_re));
        if (lkp_req)
          chk("ram_raddr_b", 64'(ram_raddr_b),
              64'(lkp_slot));
      end
    end
  end

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    #1;
    chk("rst_free_count", 64'(free_count), 8);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_slot", 64'(out_slot), 0);
    chkd("rst_out_data", out_data, '0);
    chk("rst_lkp_valid", 64'(lkp_rsp_valid), 0);
    chk("rst_lkp_err", 64'(lkp_rsp_err), 0);
    chk("rst_rel_err", 64'(rel_err), 0);
    chk("rst_ram_wren", 64'(ram_wren), 0);

    // back-to-back A, B, C
    nxt(); out_ready = 1'b1;
    in_valid = 1'b1; in_data = mk(1);
    #1 chk("t1_waddr_a", 64'(ram_waddr), 0);
    chk("t1_ov_0", 64'(out_valid), 0);
    nxt(); in_data = mk(2);
    #1 chk("t1_waddr_b", 64'(ram_waddr), 1);
    chk("t1_ov_1", 64'(out_valid), 0);
    nxt(); in_data = mk(3);
    #1 chk("t1_waddr_c", 64'(ram_waddr), 2);
    chk("t1_ov_a", 64'(out_valid), 1);
    chk("t1_slot_a", 64'(out_slot), 0);
    chkd("t1_data_a", out_data, mk(1));
    nxt(); in_valid = 1'b0;
    #1 chk("t1_slot_b", 64'(out_slot), 1);
    chkd("t1_data_b", out_data, mk(2));
    nxt();
    #1 chk("t1_slot_c", 64'(out_slot), 2);
    chkd("t1_data_c", out_data, mk(3));
    nxt();
    #1 chk("t1_ov_end", 64'(out_valid), 0);
    for (int s = 0; s < 3; s++) begin
      nxt(); rel_valid = 1'b1; rel_slot = AW'(s);
    end
    nxt(); rel_valid = 1'b0;
    #1 chk("t1_fc", 64'(free_count), 8);
    out_ready = 1'b0;

    // fill all eight slots with the consumer stalled
    for (int k = 0; k < 8; k++) begin
      nxt(); in_valid = 1'b1; in_data = mk(16 + k);
      #1 chk("t2_waddr", 64'(ram_waddr), 64'(k));
    end
    nxt(); in_data = mk(99);
    #1 chk("t2_in_ready", 64'(in_ready), 0);
    chk("t2_fc", 64'(free_count), 0);
    chk("t2_wren", 64'(ram_wren), 0);
    chk("t2_ov", 64'(out_valid), 1);
    chk("t2_slot", 64'(out_slot), 0);
    chkd("t2_data", out_data, mk(16));
    nxt(); rel_valid = 1'b1; rel_slot = 3'd7;
    #1 chk("t2_wren_b", 64'(ram_wren), 0);
    nxt(); rel_valid = 1'b0;
    #1 chk("t5_rel_err_q", 64'(rel_err), 1);
    chk("t5_fc_q", 64'(free_count), 0);
    chk("t2_slot_hold", 64'(out_slot), 0);
    chkd("t2_data_hold", out_data, mk(16));
    nxt(); in_valid = 1'b0;
    #1 chk("t5_rel_err_pulse", 64'(rel_err), 0);

    // drain, release slot 3, reuse it
    out_ready = 1'b1;
    repeat (10) nxt();
    chk("t3_drained", 64'(out_valid), 0);
    chk("t3_fc0", 64'(free_count), 0);
    rel_valid = 1'b1; rel_slot = 3'd3;
    nxt(); rel_slot = 3'd6;
    in_valid = 1'b1; in_data = mk(40);
    #1 chk("t3_fc1", 64'(free_count), 1);
    chk("t3_waddr", 64'(ram_waddr), 3);
    chk("t3_wren", 64'(ram_wren), 1);
    nxt(); rel_valid = 1'b0; in_valid = 1'b0;
    lkp_req = 1'b1; lkp_slot = 3'd5;
    #1 chk("t3_fc_same", 64'(free_count), 1);
    nxt(); lkp_slot = 3'd6;
    #1 chk("t4_lkp_v", 64'(lkp_rsp_valid), 1);
    chk("t4_lkp_err", 64'(lkp_rsp_err), 0);
    chkd("t4_lkp_data", lkp_rsp_data, mk(21));
    chk("t3_ov", 64'(out_valid), 1);
    chk("t3_slot", 64'(out_slot), 3);
    nxt(); lkp_req = 1'b0;
    rel_valid = 1'b1; rel_slot = 3'd6;
    #1 chk("t4_lkp_v6", 64'(lkp_rsp_valid), 1);
    chk("t4_lkp_err6", 64'(lkp_rsp_err), 1);
    nxt(); rel_valid = 1'b0;
    #1 chk("t5_rel_err_free", 64'(rel_err), 1);
    chk("t5_fc", 64'(free_count), 1);

    // release racing the out handshake of the same slot
    nxt(); in_valid = 1'b1; in_data = mk(50);
    #1 chk("t5_waddr6", 64'(ram_waddr), 6);
    nxt(); in_valid = 1'b0;
    nxt(); rel_valid = 1'b1; rel_slot = 3'd6;
    #1 chk("t5_ov6", 64'(out_slot), 6);
    nxt(); rel_valid = 1'b0;
    #1 chk("t5_rel_err_race", 64'(rel_err), 1);
    for (int s = 0; s < 8; s++) begin
      nxt(); rel_valid = 1'b1; rel_slot = AW'(s);
    end
    nxt(); rel_valid = 1'b0;
    #1 chk("t6_fc8", 64'(free_count), 8);

    // reset with four queued entries and a read in flight
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      nxt(); in_valid = 1'b1; in_data = mk(60 + k);
    end
    nxt(); in_data = mk(64); out_ready = 1'b1;
    nxt(); in_valid = 1'b0; out_ready = 1'b0;
    #1 chk("t6_fc_pre", 64'(free_count), 3);
    reset_n = 1'b0;
    #1 chk("t6_ov_rst", 64'(out_valid), 0);
    chk("t6_fc_rst", 64'(free_count), 8);
    chk("t6_rdy_rst", 64'(in_ready), 1);
    chk("t6_wren_rst", 64'(ram_wren), 0);
    chk("t6_lkp_rst", 64'(lkp_rsp_valid), 0);
    chk("t6_rel_err_rst", 64'(rel_err), 0);
    chkd("t6_data_rst", out_data, '0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      nxt();
      #1 chk("t6_no_stale", 64'(out_valid), 0);
    end
    chk("t6_fc_end", 64'(free_count), 8);
    chk("t6_rdy_end", 64'(in_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
